cpu_stim_seq: RTL and testbench

CPU_STIM_SEQ -- requirements
Module: cpu_stim_seq

---
 rtl/cpu_tb_pkg.sv | 17 +
 rtl/stim_rom_ram.sv | 24 ++
 rtl/cpu_stim_seq.sv | 164 ++++++++++++++++
 tb/tb_cpu_stim_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_tb_pkg.sv
// Shared definitions for the CPU stimulus sequencer: FSM encoding and default sizing.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_RST_CYCLES = 10;
  localparam int DEF_TIMEOUT    = 1024;

endpackage

// File: rtl/stim_rom_ram.sv
// Program store: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset so a program survives rst_n.
module stim_rom_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_stim_seq.sv
// Stimulus sequencer: holds a core in reset, streams a stored program to it,
// checksums the returned results and reports pass/timeout.
module cpu_stim_seq
  import cpu_tb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  input  logic [DATA_W-1:0] exp_sum,
  output logic              uut_rst_n,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycle_cnt
);

  state_t            state, state_nxt;
  logic [AW:0]       len_q, res_cnt, len_in, cnt_acc;
  logic [AW-1:0]     issue_idx;
  logic [DATA_W-1:0] exp_q, sum_q, sum_acc;
  logic [31:0]       hold_cnt, wdog, wdog_inc;
  logic              pass_q, timeout_q;
  logic              start_ok, xfer, counting, wdog_exp, fin_ok, fin_to;

  stim_rom_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk   (clk),
    .we    (load_en && (state == IDLE)),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (issue_idx),
    .rdata (instr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A result that completes the run in the same cycle the watchdog expires wins.
  always_comb begin
    state_nxt   = state;
    uut_rst_n   = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    xfer        = 1'b0;
    fin_ok      = 1'b0;
    fin_to      = 1'b0;
    start_ok    = start && ((state == IDLE) || (state == DONE));
    counting    = (state == HOLD) || (state == ISSUE) || (state == DRAIN);
    len_in      = ((prog_len == '0) || (prog_len > (AW+1)'(DEPTH))) ? (AW+1)'(DEPTH) : prog_len;
    sum_acc     = res_valid ? (sum_q + res_data) : sum_q;
    cnt_acc     = res_valid ? (res_cnt + 1'b1) : res_cnt;
    wdog_inc    = wdog + 32'd1;
    wdog_exp    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == 32'(RST_CYCLES - 1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        uut_rst_n   = 1'b1;
        instr_valid = 1'b1;
        xfer        = instr_ready;
        wdog_exp    = !xfer && !res_valid && (wdog_inc == 32'(TIMEOUT));
        if (xfer && ({1'b0, issue_idx} == len_q - 1'b1)) begin
          state_nxt = DRAIN;
        end else if (wdog_exp) begin
          state_nxt = DONE;
          fin_to    = 1'b1;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        uut_rst_n = 1'b1;
        wdog_exp  = !res_valid && (wdog_inc == 32'(TIMEOUT));
        if (cnt_acc >= len_q) begin
          state_nxt = DONE;
          fin_ok    = 1'b1;
        end else if (wdog_exp) begin
          state_nxt = DONE;
          fin_to    = 1'b1;
        end
      end
      DONE: begin
        uut_rst_n = 1'b1;
        done      = 1'b1;
        if (start_ok) state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run datapath: counters, checksum, watchdog and latched verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      exp_q     <= '0;
      sum_q     <= '0;
      res_cnt   <= '0;
      issue_idx <= '0;
      hold_cnt  <= '0;
      wdog      <= '0;
      cycle_cnt <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      len_q     <= len_in;
      exp_q     <= exp_sum;
      sum_q     <= '0;
      res_cnt   <= '0;
      issue_idx <= '0;
      hold_cnt  <= '0;
      wdog      <= '0;
      cycle_cnt <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (counting && res_valid) begin
        sum_q   <= sum_acc;
        res_cnt <= cnt_acc;
      end
      if (xfer) issue_idx <= issue_idx + 1'b1;
      if ((state == ISSUE) || (state == DRAIN)) begin
        wdog <= (xfer || res_valid) ? 32'd0 : wdog_inc;
      end
      if (uut_rst_n && (state != DONE) && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (fin_ok) begin
        pass_q    <= (sum_acc == exp_q);
        timeout_q <= 1'b0;
      end else if (fin_to) begin
        pass_q    <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_stim_seq.sv
// Directed bench for cpu_stim_seq: a small core model answers each transfer
// with a result from resp_tab; expectations are hand-computed per scenario.
module tb_cpu_stim_seq;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk, rst_n;
  logic              load_en, start;
  logic [AW-1:0]     load_addr;
  logic [DATA_W-1:0] load_data, exp_sum;
  logic [AW:0]       prog_len;
  logic              uut_rst_n, instr_valid, instr_ready;
  logic [DATA_W-1:0] instr_data, res_data;
  logic              res_valid, busy, done, pass, timeout;
  logic [31:0]       cycle_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic              core_en      = 1'b1;
  logic              ready_toggle = 1'b0;
  logic [DATA_W-1:0] resp_tab [4];
  int                run_id = 0;

  int                seen_id = 0;
  int                res_k, xfer_n, hold_cyc, drain_cyc, stalls, stall_errs;
  logic              have_stall;
  logic [DATA_W-1:0] stall_data;
  logic [DATA_W-1:0] xfer_log [8];

  cpu_stim_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYCLES(10), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .prog_len(prog_len), .exp_sum(exp_sum),
    .uut_rst_n(uut_rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model and run observers, all evaluated mid-cycle.
  initial begin
    instr_ready = 1'b1;
    res_valid   = 1'b0;
    res_data    = '0;
    have_stall  = 1'b0;
    stall_data  = '0;
    res_k = 0; xfer_n = 0; hold_cyc = 0; drain_cyc = 0; stalls = 0; stall_errs = 0;
    forever begin
      @(negedge clk);
      if (run_id != seen_id) begin
        seen_id = run_id;
        res_k = 0; xfer_n = 0; hold_cyc = 0; drain_cyc = 0;
        stalls = 0; stall_errs = 0; have_stall = 1'b0;
      end
      instr_ready = ready_toggle ? ~instr_ready : 1'b1;
      if (have_stall) begin
        stalls++;
        if (!instr_valid || (instr_data != stall_data)) stall_errs++;
      end
      have_stall = instr_valid && !instr_ready;
      stall_data = instr_data;
      if (instr_valid && instr_ready) begin
        if (xfer_n < 8) xfer_log[xfer_n] = instr_data;
        xfer_n++;
        res_valid = core_en;
        res_data  = (res_k < 4) ? resp_tab[res_k] : '0;
        if (core_en) res_k++;
      end else begin
        res_valid = 1'b0;
      end
      if (busy && !uut_rst_n) hold_cyc++;
      if (busy && uut_rst_n && !instr_valid) drain_cyc++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    step();
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW:0] len, input logic [DATA_W-1:0] sum);
    step();
    run_id++;
    start = 1'b1; prog_len = len; exp_sum = sum;
    step();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      step();
    end
    checkOutput("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic setResp(input logic [DATA_W-1:0] a, b, c, d);
    resp_tab[0] = a; resp_tab[1] = b; resp_tab[2] = c; resp_tab[3] = d;
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; prog_len = '0; exp_sum = '0;
    setResp(8'd1, 8'd2, 8'd3, 8'd4);

    repeat (2) step();
    checkOutput("rst_uut_rst_n", {31'd0, uut_rst_n}, 32'd0);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_cycle_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) loadWord(AW'(i), 8'hA0 + 8'(i));

    // Basic run: 1+2+3+4 = 10, four ISSUE cycles plus one DRAIN cycle.
    applyStimulus(3'd4, 8'd10);
    waitDone(100);
    checkOutput("run1_pass", {31'd0, pass}, 32'd1);
    checkOutput("run1_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("run1_hold", hold_cyc, 32'd10);
    checkOutput("run1_cycle_cnt", cycle_cnt, 32'd5);
    checkOutput("run1_xfers", xfer_n, 32'd4);

    loadWord(2'd0, 8'h55);
    applyStimulus(3'd4, 8'd11);
    waitDone(100);
    checkOutput("run2_pass", {31'd0, pass}, 32'd0);
    checkOutput("run2_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("run2_word0_kept", {24'd0, xfer_log[0]}, 32'h0A0);

    // Stalled handshake; a start pulse mid-ISSUE must be ignored.
    ready_toggle = 1'b1;
    applyStimulus(3'd4, 8'd10);
    repeat (12) step();
    checkOutput("tog_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; prog_len = 3'd1; exp_sum = 8'd0;
    step();
    start = 1'b0;
    waitDone(100);
    ready_toggle = 1'b0;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("tog_word%0d", i), {24'd0, xfer_log[i]}, 32'hA0 + 32'(i));
    checkOutput("tog_stall_stable", stall_errs, 32'd0);
    checkOutput("tog_stalls_seen", {31'd0, (stalls >= 3)}, 32'd1);
    checkOutput("tog_hold", hold_cyc, 32'd10);
    checkOutput("tog_pass", {31'd0, pass}, 32'd1);

    // No results: 16 DRAIN cycles after the last transfer, then timeout.
    core_en = 1'b0;
    applyStimulus(3'd2, 8'd0);
    waitDone(200);
    core_en = 1'b1;
    checkOutput("to_timeout", {31'd0, timeout}, 32'd1);
    checkOutput("to_pass", {31'd0, pass}, 32'd0);
    checkOutput("to_drain_cycles", drain_cyc, 32'd16);
    checkOutput("to_cycle_cnt", cycle_cnt, 32'd18);

    // Reset pulse mid-ISSUE, then a clean rerun.
    applyStimulus(3'd4, 8'd10);
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) break;
      step();
    end
    checkOutput("mid_issue_wait", {31'd0, instr_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mid_rst_uut", {31'd0, uut_rst_n}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(3'd4, 8'd10);
    waitDone(100);
    checkOutput("rerun_pass", {31'd0, pass}, 32'd1);
    checkOutput("rerun_word0", {24'd0, xfer_log[0]}, 32'h0A0);

    // prog_len=0 clamps to DEPTH; 0xFF+0x02 wraps to 0x01.
    setResp(8'hFF, 8'h02, 8'h00, 8'h00);
    applyStimulus(3'd0, 8'h01);
    waitDone(100);
    checkOutput("wrap_pass", {31'd0, pass}, 32'd1);
    checkOutput("wrap_xfers", xfer_n, 32'd4);
    checkOutput("wrap_last_word", {24'd0, xfer_log[3]}, 32'h0A3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
